// File: rtl/fpu_avalon_master.sv
// fpu_avalon_master
//   Avalon-MM initiator for the memory-mapped FPU adder slave. It accepts an
//   operand pair from a datapath client and writes A, then B, to the slave.
//   It then reads the result word and hands it back to the client. Every
//   command honours waitrequest. A command stalled for TIMEOUT consecutive
//   cycles is dropped, and NAN_VALUE is returned with err set.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   in_a/in_b        operand pair, qualified by in_stb
//   in_stb/in_ack    operand handshake (in_ack is a one-cycle pulse)
//   out_z/err        result and timeout flag, qualified by out_stb
//   out_stb/out_ack  result handshake (out_stb holds until out_ack)
//   avm_*            Avalon-MM initiator port
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for an operand pair
// S_WR_A    | write of operand A on the bus
// S_WR_B    | write of operand B on the bus
// S_RD_REQ  | read of the result word on the bus
// S_RD_WAIT | read accepted, counting down to the readdata edge
// S_OUT     | result presented to the client, waiting for out_ack

module fpu_avalon_master #(
    parameter logic [2:0]  ADDR_A       = 3'h0,
    parameter logic [2:0]  ADDR_B       = 3'h1,
    parameter logic [2:0]  ADDR_Z       = 3'h2,
    parameter int          READ_LATENCY = 1,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] NAN_VALUE    = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] out_z,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        err,
    output logic [2:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD_REQ,
        S_RD_WAIT,
        S_OUT
    } state_t;

    localparam logic [7:0] STALL_INIT = 8'(TIMEOUT);
    // Counter reaches zero on the edge that must capture readdata.
    localparam logic [2:0] LAT_INIT   = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    state_t      r_state,      w_state;
    logic        r_in_ack,     w_in_ack;
    logic [31:0] r_out_z,      w_out_z;
    logic        r_out_stb,    w_out_stb;
    logic        r_err,        w_err;
    logic [2:0]  r_addr,       w_addr;
    logic [31:0] r_wdata,      w_wdata;
    logic        r_write,      w_write;
    logic        r_read,       w_read;
    logic [31:0] r_b,          w_b;
    logic [7:0]  r_stall_left, w_stall_left;
    logic [2:0]  r_lat_cnt,    w_lat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_ack     <= 1'b0;
            r_out_z      <= '0;
            r_out_stb    <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_read       <= 1'b0;
            r_b          <= '0;
            r_stall_left <= '0;
            r_lat_cnt    <= '0;
        end else begin
            r_state      <= w_state;
            r_in_ack     <= w_in_ack;
            r_out_z      <= w_out_z;
            r_out_stb    <= w_out_stb;
            r_err        <= w_err;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_write      <= w_write;
            r_read       <= w_read;
            r_b          <= w_b;
            r_stall_left <= w_stall_left;
            r_lat_cnt    <= w_lat_cnt;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_in_ack     = 1'b0;
        w_out_z      = r_out_z;
        w_out_stb    = r_out_stb;
        w_err        = r_err;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_write      = r_write;
        w_read       = r_read;
        w_b          = r_b;
        w_stall_left = r_stall_left;
        w_lat_cnt    = r_lat_cnt;

        case (r_state)
            S_IDLE: begin
                if (in_stb && !r_in_ack) begin
                    // writedata itself holds A; only B needs a holding register
                    w_in_ack     = 1'b1;
                    w_b          = in_b;
                    w_write      = 1'b1;
                    w_addr       = ADDR_A;
                    w_wdata      = in_a;
                    w_stall_left = STALL_INIT;
                    w_state      = S_WR_A;
                end
            end

            S_WR_A, S_WR_B, S_RD_REQ: begin
                if (avm_waitrequest) begin
                    // Stall budget counts down; the last allowed stall aborts.
                    if (r_stall_left <= 8'd1) begin
                        w_write   = 1'b0;
                        w_read    = 1'b0;
                        w_out_z   = NAN_VALUE;
                        w_err     = 1'b1;
                        w_out_stb = 1'b1;
                        w_state   = S_OUT;
                    end else begin
                        w_stall_left = r_stall_left - 8'd1;
                    end
                end else begin
                    w_stall_left = STALL_INIT;
                    case (r_state)
                        S_WR_A: begin
                            w_addr  = ADDR_B;
                            w_wdata = r_b;
                            w_state = S_WR_B;
                        end
                        S_WR_B: begin
                            w_write = 1'b0;
                            w_read  = 1'b1;
                            w_addr  = ADDR_Z;
                            w_state = S_RD_REQ;
                        end
                        default: begin
                            w_read = 1'b0;
                            if (READ_LATENCY == 0) begin
                                w_out_z   = avm_readdata;
                                w_err     = 1'b0;
                                w_out_stb = 1'b1;
                                w_state   = S_OUT;
                            end else begin
                                w_lat_cnt = LAT_INIT;
                                w_state   = S_RD_WAIT;
                            end
                        end
                    endcase
                end
            end

            S_RD_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_out_z   = avm_readdata;
                    w_err     = 1'b0;
                    w_out_stb = 1'b1;
                    w_state   = S_OUT;
                end else begin
                    w_lat_cnt = r_lat_cnt - 3'd1;
                end
            end

            S_OUT: begin
                if (out_ack) begin
                    w_out_stb = 1'b0;
                    w_err     = 1'b0;
                    w_state   = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign in_ack        = r_in_ack;
    assign out_z         = r_out_z;
    assign out_stb       = r_out_stb;
    assign err           = r_err;
    assign avm_address   = r_addr;
    assign avm_writedata = r_wdata;
    assign avm_write     = r_write;
    assign avm_read      = r_read;

endmodule

// File: tb/tb_fpu_avalon_master.sv
// Bench for fpu_avalon_master. A transaction-level model of one operation
// (write A, write B, read Z, then result or timeout NaN) drives a scripted
// Avalon slave and checks the bus and client handshakes cycle by cycle.
// Operands, results, stall lengths and ack delays are randomized.

module tb_fpu_avalon_master;

    localparam logic [2:0]  ADDR_A_P = 3'h0;
    localparam logic [2:0]  ADDR_B_P = 3'h1;
    localparam logic [2:0]  ADDR_Z_P = 3'h2;
    localparam int          RL_P     = 1;
    localparam int          TO_P     = 255;
    localparam logic [31:0] NAN_P    = 32'h7FC00000;
    localparam int          N_RAND   = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [31:0] out_z;
    logic        out_stb;
    logic        out_ack = 1'b0;
    logic        err;
    logic [2:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    fpu_avalon_master #(
        .ADDR_A(ADDR_A_P), .ADDR_B(ADDR_B_P), .ADDR_Z(ADDR_Z_P),
        .READ_LATENCY(RL_P), .TIMEOUT(TO_P), .NAN_VALUE(NAN_P)
    ) dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_b(in_b), .in_stb(in_stb), .in_ack(in_ack),
        .out_z(out_z), .out_stb(out_stb), .out_ack(out_ack), .err(err),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus command: checks it is presented, stalls it n_stall cycles,
    // then lets it complete. Returns timed_out when the stall budget ends it.
    task automatic do_cmd(input bit is_wr, input logic [2:0] addr, input logic [31:0] data,
                          input int n_stall, output bit timed_out);
        int stalls;
        stalls    = 0;
        timed_out = 1'b0;
        while (1) begin
            check_val("cmd_write", 32'(avm_write), 32'(is_wr));
            check_val("cmd_read", 32'(avm_read), 32'(!is_wr));
            check_val("cmd_addr", 32'(avm_address), 32'(addr));
            if (is_wr) check_val("cmd_wdata", avm_writedata, data);
            avm_readdata = $urandom;
            if (stalls < n_stall) begin
                avm_waitrequest = 1'b1;
                @(negedge clk);
                stalls++;
                if (stalls == TO_P) begin
                    timed_out       = 1'b1;
                    avm_waitrequest = 1'b0;
                    return;
                end
            end else begin
                avm_waitrequest = 1'b0;
                @(negedge clk);
                return;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                          input int sa, input int sb, input int sr, input int ack_dly,
                          input bit chain, input logic [31:0] na, input logic [31:0] nb);
        bit          to;
        logic [31:0] exp_z;
        logic        exp_err;
        int          t0;
        in_a   = a;
        in_b   = b;
        in_stb = 1'b1;
        @(negedge clk);
        check_val("in_ack", 32'(in_ack), 32'd1);
        t0     = cyc_cnt;
        in_stb = 1'b0;
        in_a   = $urandom;
        in_b   = $urandom;
        do_cmd(1'b1, ADDR_A_P, a, sa, to);
        check_val("in_ack_pulse", 32'(in_ack), 32'd0);
        if (!to) do_cmd(1'b1, ADDR_B_P, b, sb, to);
        if (!to) do_cmd(1'b0, ADDR_Z_P, 32'd0, sr, to);
        if (to) begin
            exp_z   = NAN_P;
            exp_err = 1'b1;
        end else begin
            exp_z   = z;
            exp_err = 1'b0;
            for (int k = 1; k <= RL_P; k++) begin
                check_val("rd_dropped", 32'(avm_read), 32'd0);
                check_val("early_stb", 32'(out_stb), 32'd0);
                avm_readdata    = (k == RL_P) ? z : ~z;
                avm_waitrequest = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        avm_readdata    = ~exp_z;
        avm_waitrequest = 1'b0;
        check_val("out_stb", 32'(out_stb), 32'd1);
        check_val("out_z", out_z, exp_z);
        check_val("err", 32'(err), 32'(exp_err));
        check_val("bus_idle_w", 32'(avm_write), 32'd0);
        check_val("bus_idle_r", 32'(avm_read), 32'd0);
        if (sa == 0 && sb == 0 && sr == 0)
            check_val("latency", 32'(cyc_cnt - t0), 32'(3 + RL_P));
        if (chain) begin
            in_a   = na;
            in_b   = nb;
            in_stb = 1'b1;
        end
        for (int i = 0; i < ack_dly; i++) begin
            out_ack = 1'b0;
            avm_readdata = $urandom;
            @(negedge clk);
            check_val("hold_stb", 32'(out_stb), 32'd1);
            check_val("hold_z", out_z, exp_z);
            check_val("hold_err", 32'(err), 32'(exp_err));
            check_val("no_ack_in_out", 32'(in_ack), 32'd0);
        end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check_val("stb_clear", 32'(out_stb), 32'd0);
        check_val("err_clear", 32'(err), 32'd0);
        check_val("no_ack_on_exit", 32'(in_ack), 32'd0);
    endtask

    logic [31:0] ra [N_RAND+1];
    logic [31:0] rb [N_RAND+1];
    logic [31:0] rz [N_RAND+1];

    initial begin
        bit to;
        bit ch;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_in_ack", 32'(in_ack), 32'd0);
        check_val("rst_out_stb", 32'(out_stb), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_out_z", out_z, 32'd0);
        check_val("rst_write", 32'(avm_write), 32'd0);
        check_val("rst_read", 32'(avm_read), 32'd0);
        check_val("rst_addr", 32'(avm_address), 32'd0);
        check_val("rst_wdata", avm_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ideal slave
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 1'b0, 32'd0, 32'd0);
        // B write stalled 5 cycles
        run_op(32'h3F800000, 32'h40000000, 32'h40400000, 0, 5, 0, 1, 1'b0, 32'd0, 32'd0);
        // read stalled 20 cycles while the slave computes
        run_op($urandom, $urandom, 32'h41200000, 0, 0, 20, 0, 1'b0, 32'd0, 32'd0);
        // longest stall that still completes
        run_op($urandom, $urandom, 32'hC0A00000, 254, 0, 0, 0, 1'b0, 32'd0, 32'd0);
        // waitrequest stuck: read times out after 255 stalls
        run_op($urandom, $urandom, 32'h12345678, 0, 0, 1000, 2, 1'b0, 32'd0, 32'd0);
        // timeout on the A write
        run_op($urandom, $urandom, 32'h87654321, 300, 0, 0, 0, 1'b0, 32'd0, 32'd0);
        // out_ack withheld with the next pair already waiting, then back to back
        run_op(32'h40800000, 32'h40A00000, 32'h41100000, 0, 0, 0, 10, 1'b1, 32'h3F000000, 32'h3E800000);
        run_op(32'h3F000000, 32'h3E800000, 32'h3F400000, 0, 0, 0, 0, 1'b0, 32'd0, 32'd0);

        // reset while the B write is stalled
        in_a   = 32'hAAAA5555;
        in_b   = 32'h5555AAAA;
        in_stb = 1'b1;
        @(negedge clk);
        check_val("rst_op_ack", 32'(in_ack), 32'd1);
        in_stb = 1'b0;
        do_cmd(1'b1, ADDR_A_P, 32'hAAAA5555, 0, to);
        check_val("rst_op_wr_b", 32'(avm_write), 32'd1);
        check_val("rst_op_addr_b", 32'(avm_address), 32'(ADDR_B_P));
        avm_waitrequest = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        check_val("mid_rst_write", 32'(avm_write), 32'd0);
        check_val("mid_rst_read", 32'(avm_read), 32'd0);
        check_val("mid_rst_stb", 32'(out_stb), 32'd0);
        check_val("mid_rst_addr", 32'(avm_address), 32'd0);
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1'b0, 32'd0, 32'd0);

        // randomized traffic
        for (int i = 0; i <= N_RAND; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rz[i] = $urandom;
        end
        for (int i = 0; i < N_RAND; i++) begin
            ch = ($urandom_range(0, 1) == 1) && (i < N_RAND - 1);
            run_op(ra[i], rb[i], rz[i],
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0,
                   $urandom_range(0, 4), ch, ra[i+1], rb[i+1]);
            if (!ch) begin
                // idle gap with in_stb low: nothing may start
                for (int g = 0; g < $urandom_range(0, 2); g++) begin
                    in_a = $urandom;
                    @(negedge clk);
                    check_val("idle_no_ack", 32'(in_ack), 32'd0);
                    check_val("idle_no_write", 32'(avm_write), 32'd0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
